// File: rtl/latch_bank_ctrl.sv
// Round-robin write controller for a bank of level-sensitive D latches.
// Each write runs setup / open-enable / hold so latch data is stable around the enable window.
module latch_bank_ctrl #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int NLATCH   = 8,
  parameter int AW       = 3,
  parameter int OPEN_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int CLR_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  input  logic                 clr_req,
  output logic                 clr_ack,
  output logic [DW-1:0]        lat_d,
  output logic [NLATCH-1:0]    lat_en,
  output logic                 lat_rstn,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, OPEN, HOLD, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic              win_valid;
  logic [AW-1:0]     addr_q;
  logic [3:0]        cnt;
  logic [AW-1:0]     addr_arr [NREQ];
  logic [DW-1:0]     data_arr [NREQ];
  logic [NLATCH-1:0] en_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
    // Addresses beyond the bank match no decoder bit, so such writes open nothing.
    for (gi = 0; gi < NLATCH; gi++) begin : g_dec
      assign en_dec[gi] = (addr_q == AW'(gi));
    end
  endgenerate

  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!win_valid && req[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      ack      <= '0;
      clr_ack  <= 1'b0;
      lat_d    <= '0;
      lat_en   <= '0;
      lat_rstn <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ack      <= '0;
      clr_ack  <= 1'b0;
      lat_rstn <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            lat_rstn <= 1'b0;
            cnt      <= 4'(CLR_CYC - 1);
          end else if (win_valid) begin
            state  <= SETUP;
            busy   <= 1'b1;
            grant  <= win;
            addr_q <= addr_arr[win];
            lat_d  <= data_arr[win];
          end
        end
        // The clr_ack cycle is spent inside CLEAR so a still-high clr_req is not resampled.
        CLEAR: begin
          if (clr_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            lat_rstn <= 1'b0;
          end else begin
            clr_ack <= 1'b1;
          end
        end
        SETUP: begin
          state  <= OPEN;
          lat_en <= en_dec;
          cnt    <= 4'(OPEN_CYC - 1);
        end
        OPEN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= HOLD;
            lat_en <= '0;
            cnt    <= 4'(HOLD_CYC - 1);
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= DONE;
            ack[grant] <= 1'b1;
            rr_ptr     <= (grant == PW'(NREQ - 1)) ? '0 : PW'(grant + 1'b1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Bench for latch_bank_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_latch_bank_ctrl;

  localparam int NREQ = 4, DW = 8, NLATCH = 8, AW = 3;
  localparam int OPEN_CYC = 2, HOLD_CYC = 1, CLR_CYC = 2;
  localparam int WR_LEN = 2 + OPEN_CYC + HOLD_CYC;  // cycles from SETUP through the ack cycle
  localparam int CL_LEN = CLR_CYC + 1;              // reset-low cycles plus the clr_ack cycle

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic              clr_req = 1'b0;
  logic [NREQ-1:0]   ack;
  logic              clr_ack;
  logic [DW-1:0]     lat_d;
  logic [NLATCH-1:0] lat_en;
  logic              lat_rstn;
  logic              busy;

  logic [NREQ-1:0]    b_req = '0;
  logic [NREQ*AW-1:0] b_addr = '0;
  logic [NREQ*DW-1:0] b_data = '0;
  logic               b_clr_req = 1'b0;
  logic [NREQ-1:0]    b_ack;
  logic               b_clr_ack;
  logic [DW-1:0]      b_lat_d;
  logic [NLATCH-1:0]  b_lat_en;
  logic               b_lat_rstn;
  logic               b_busy;

  always #5 clk = ~clk;

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .NLATCH(NLATCH), .AW(AW),
                    .OPEN_CYC(OPEN_CYC), .HOLD_CYC(HOLD_CYC), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .clr_req(clr_req), .clr_ack(clr_ack), .lat_d(lat_d),
    .lat_en(lat_en), .lat_rstn(lat_rstn), .busy(busy)
  );

  latch_bank_ctrl #(.NREQ(NREQ), .DW(DW), .NLATCH(NLATCH), .AW(AW),
                    .OPEN_CYC(1), .HOLD_CYC(3), .CLR_CYC(CLR_CYC)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .req_addr(b_addr), .req_data(b_data),
    .ack(b_ack), .clr_req(b_clr_req), .clr_ack(b_clr_ack), .lat_d(b_lat_d),
    .lat_en(b_lat_en), .lat_rstn(b_lat_rstn), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Timeline model: an operation granted at edge m_start drives its outputs by cycle offset.
  int               m_cyc, m_start, m_kind, m_grant, m_addr, m_ptr, m_p, m_j;
  logic [DW-1:0]    m_last_d;
  logic [NREQ-1:0]  exp_ack;
  logic             exp_clr_ack, exp_rstn, exp_busy;
  logic [DW-1:0]    exp_d;
  logic [NLATCH-1:0] exp_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_start = 0; m_kind = 0; m_ptr = 0; m_grant = 0; m_addr = 0;
      m_last_d = '0;
      exp_ack = '0; exp_clr_ack = 1'b0; exp_d = '0; exp_en = '0;
      exp_rstn = 1'b0; exp_busy = 1'b0;
    end else begin
      m_cyc++;
      if (m_kind != 0 && (m_cyc - m_start) == ((m_kind == 1) ? WR_LEN : CL_LEN)) begin
        if (m_kind == 1) m_ptr = (m_grant + 1) % NREQ;
        m_kind = 0;
      end else if (m_kind == 0) begin
        if (clr_req) begin
          m_kind = 2; m_start = m_cyc;
        end else if (req != '0) begin
          for (int k = 0; k < NREQ; k++) begin
            m_j = (m_ptr + k) % NREQ;
            if (req[m_j]) begin
              m_grant = m_j;
              break;
            end
          end
          m_kind = 1; m_start = m_cyc;
          m_addr = int'(req_addr[m_grant*AW +: AW]);
          m_last_d = req_data[m_grant*DW +: DW];
        end
      end
      m_p = m_cyc - m_start + 1;
      exp_ack = '0; exp_clr_ack = 1'b0; exp_en = '0; exp_rstn = 1'b1;
      exp_busy = (m_kind != 0);
      exp_d = m_last_d;
      if (m_kind == 1) begin
        if (m_p >= 2 && m_p <= 1 + OPEN_CYC && m_addr < NLATCH) exp_en = NLATCH'(1) << m_addr;
        if (m_p == WR_LEN) exp_ack[m_grant] = 1'b1;
      end else if (m_kind == 2) begin
        if (m_p <= CLR_CYC) exp_rstn = 1'b0;
        if (m_p == CL_LEN) exp_clr_ack = 1'b1;
      end
    end
  end

  wire [NREQ+DW+NLATCH+2:0] obs_v = {ack, clr_ack, lat_d, lat_en, lat_rstn, busy};
  wire [NREQ+DW+NLATCH+2:0] exp_v = {exp_ack, exp_clr_ack, exp_d, exp_en, exp_rstn, exp_busy};

  function automatic string obs_s();
    return $sformatf("ack=%b clr_ack=%b d=%h en=%b rstn=%b busy=%b",
                     ack, clr_ack, lat_d, lat_en, lat_rstn, busy);
  endfunction

  function automatic string exp_s();
    return $sformatf("ack=%b clr_ack=%b d=%h en=%b rstn=%b busy=%b",
                     exp_ack, exp_clr_ack, exp_d, exp_en, exp_rstn, exp_busy);
  endfunction

  always @(negedge clk) begin
    if (!rst && (|ack)) $display("write done: ack=%b lat_d=%h", ack, lat_d);
    if (!rst && clr_ack) $display("clear done");
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({ack, clr_ack, lat_d, lat_en, lat_rstn, busy} !== '0)
      $display("FAIL reset_values got %s want all zero", obs_s());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (lat_rstn !== 1'b0 || b_lat_rstn !== 1'b0)
      $display("FAIL reset_rstn_low got %b/%b want 0/0", lat_rstn, b_lat_rstn);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (lat_rstn !== 1'b1 || b_lat_rstn !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release got rstn=%b/%b busy=%b want 1/1 0", lat_rstn, b_lat_rstn, busy);
    else n_pass++;
  endtask

  task automatic test_single_write();
    req = 4'b0001;
    req_addr[0 +: AW] = 3'd5;
    req_data[0 +: DW] = 8'hA5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_single k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      n_checks++;
      case (k)
        1: if (lat_d !== 8'hA5 || lat_en !== 8'h00 || busy !== 1'b1)
             $display("FAIL single_setup got d=%h en=%h busy=%b want a5 00 1", lat_d, lat_en, busy);
           else n_pass++;
        2, 3: if (lat_en !== 8'h20 || lat_d !== 8'hA5)
             $display("FAIL single_open k=%0d got en=%h d=%h want 20 a5", k, lat_en, lat_d);
           else n_pass++;
        4: if (lat_en !== 8'h00 || lat_d !== 8'hA5 || ack !== 4'b0000)
             $display("FAIL single_hold got en=%h d=%h ack=%b want 00 a5 0000", lat_en, lat_d, ack);
           else n_pass++;
        5: if (ack !== 4'b0001)
             $display("FAIL single_ack got %b want 0001", ack);
           else n_pass++;
        default: if (busy !== 1'b0 || ack !== 4'b0000 || lat_d !== 8'hA5)
             $display("FAIL single_idle got busy=%b ack=%b d=%h want 0 0000 a5", busy, ack, lat_d);
           else n_pass++;
      endcase
      if (k == 5) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int want[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = 3'($urandom);
      req_data[i*DW +: DW] = 8'(16 * i + $urandom_range(0, 15));
    end
    req = 4'b1111;
    for (int k = 0; k < 60 && got.size() < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rr k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      n_checks++;
      if (!$onehot0(lat_en)) $display("FAIL rr_onehot got en=%b want at most one bit", lat_en);
      else n_pass++;
      for (int i = 0; i < NREQ; i++) if (ack[i]) got.push_back(i);
      if (got.size() >= 5) req = '0;
    end
    n_checks++;
    if (got.size() != 5) $display("FAIL rr_count got %0d acks want 5", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got[i] != want[i]) $display("FAIL rr_order slot %0d got req%0d want req%0d", i, got[i], want[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clear_priority();
    logic [DW-1:0] d2;
    idle_cycles(2);
    d2 = 8'($urandom);
    req_addr[2*AW +: AW] = 3'd3;
    req_data[2*DW +: DW] = d2;
    req = 4'b0100;
    clr_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_clrpri k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      if (k <= 2) begin
        n_checks++;
        if (lat_rstn !== 1'b0 || lat_en !== '0) $display("FAIL clrpri_low k=%0d got rstn=%b en=%h want 0 00", k, lat_rstn, lat_en);
        else n_pass++;
      end
      if (k == 3) begin
        n_checks++;
        if (clr_ack !== 1'b1 || lat_rstn !== 1'b1) $display("FAIL clrpri_ack got clr_ack=%b rstn=%b want 1 1", clr_ack, lat_rstn);
        else n_pass++;
        clr_req = 1'b0;
      end
      if (k == 9) begin
        n_checks++;
        if (ack !== 4'b0100 || lat_d !== d2) $display("FAIL clrpri_write got ack=%b d=%h want 0100 %h", ack, lat_d, d2);
        else n_pass++;
        req = '0;
      end
    end
  endtask

  task automatic test_clear_midwrite();
    idle_cycles(1);
    req_addr[1*AW +: AW] = 3'd2;
    req_data[1*DW +: DW] = 8'($urandom);
    req = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_clrmid k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      if (k == 2) clr_req = 1'b1;
      if (k == 5) begin
        n_checks++;
        if (ack !== 4'b0010) $display("FAIL clrmid_ack got %b want 0010", ack);
        else n_pass++;
        req = '0;
      end
      if (k == 7) begin
        n_checks++;
        if (lat_rstn !== 1'b0 || busy !== 1'b1) $display("FAIL clrmid_clear got rstn=%b busy=%b want 0 1", lat_rstn, busy);
        else n_pass++;
      end
      if (k == 9) begin
        n_checks++;
        if (clr_ack !== 1'b1) $display("FAIL clrmid_clr_ack got %b want 1", clr_ack);
        else n_pass++;
        clr_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midop();
    int n_acks = 0;
    idle_cycles(1);
    req_addr[3*AW +: AW] = 3'd6;
    req_data[3*DW +: DW] = 8'($urandom);
    req = 4'b1000;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rstmid got %s want %s", obs_s(), exp_s());
      else n_pass++;
    end
    n_checks++;
    if (lat_en !== 8'h40) $display("FAIL rstmid_open got en=%h want 40", lat_en);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({lat_en, lat_rstn, busy, ack} !== '0)
      $display("FAIL rstmid_async got en=%h rstn=%b busy=%b ack=%b want all zero", lat_en, lat_rstn, busy, ack);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0000 || lat_rstn !== 1'b0) $display("FAIL rstmid_hold got ack=%b rstn=%b want 0000 0", ack, lat_rstn);
    else n_pass++;
    rst = 1'b0;
    req_addr[0 +: AW] = 3'd1;
    req_data[0 +: DW] = 8'($urandom);
    req = 4'b1001;
    for (int k = 0; k < 40 && req != '0; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rstmid k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      if (|ack) begin
        if (n_acks == 0) begin
          n_checks++;
          if (ack !== 4'b0001) $display("FAIL rstmid_first_grant got ack=%b want 0001", ack);
          else n_pass++;
        end
        n_acks++;
        req = req & ~ack;
      end
    end
    n_checks++;
    if (req !== '0) $display("FAIL rstmid_timeout got pending req=%b want 0000", req);
    else n_pass++;
  endtask

  task automatic test_random();
    idle_cycles(1);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rand k=%0d got %s want %s", k, obs_s(), exp_s());
      else n_pass++;
      n_checks++;
      if (!$onehot0(lat_en) || ((|lat_en) && !lat_rstn))
        $display("FAIL rand_en_safety got en=%b rstn=%b want one-hot-or-zero and not during clear", lat_en, lat_rstn);
      else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          req_addr[i*AW +: AW] = 3'($urandom);
          req_data[i*DW +: DW] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_addr[i*AW +: AW] = 3'($urandom);
            req_data[i*DW +: DW] = 8'($urandom);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          req_data[i*DW +: DW] = 8'($urandom);
        end else if ($urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (clr_ack) clr_req = 1'b0;
      else if (!clr_req && $urandom_range(0, 29) == 0) clr_req = 1'b1;
    end
    req = '0;
    clr_req = 1'b0;
  endtask

  task automatic test_timing_params();
    logic [DW-1:0]     x, y, e_d;
    logic [NLATCH-1:0] e_en;
    logic [NREQ-1:0]   e_ack;
    logic              e_busy;
    x = 8'($urandom);
    y = ~x;
    b_addr[0 +: AW] = 3'd7;
    b_data[0 +: DW] = x;
    b_req = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      e_en   = (k == 2) ? 8'h80 : (k == 9) ? 8'h01 : 8'h00;
      e_d    = (k <= 7) ? x : y;
      e_ack  = (k == 6 || k == 13) ? 4'b0001 : 4'b0000;
      e_busy = !(k == 7 || k == 14);
      n_checks++;
      if ({b_lat_en, b_lat_d, b_ack, b_busy, b_lat_rstn, b_clr_ack} !== {e_en, e_d, e_ack, e_busy, 1'b1, 1'b0})
        $display("FAIL timing_b k=%0d got en=%h d=%h ack=%b busy=%b rstn=%b clr_ack=%b want en=%h d=%h ack=%b busy=%b rstn=1 clr_ack=0",
                 k, b_lat_en, b_lat_d, b_ack, b_busy, b_lat_rstn, b_clr_ack, e_en, e_d, e_ack, e_busy);
      else n_pass++;
      if (k == 6) begin
        b_addr[0 +: AW] = 3'd0;
        b_data[0 +: DW] = y;
      end
      if (k == 13) b_req = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_priority();
    test_clear_midwrite();
    test_reset_midop();
    test_random();
    test_timing_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
